// File: rtl/keypad_pkg.sv
// Shared types and key-map decoding for the 4x4 matrix keypad front end.
package keypad_pkg;

   typedef enum logic [2:0] {
      SCAN,
      DEBOUNCE,
      EMIT_SETUP,
      EMIT_STROBE,
      EQ_WAIT,
      WAIT_RELEASE
   } kp_state_t;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b100;

   typedef enum logic [1:0] {
      DIGIT,
      OPER,
      EQUAL,
      NONE
   } key_class_t;

   typedef struct packed {
      key_class_t cls;
      logic [3:0] value;
   } key_t;

   // Operator keys carry their one-hot code in value[2:0].
   function automatic key_t decode_key(input logic [1:0] row, input logic [1:0] col);
      key_t k;
      k.cls   = NONE;
      k.value = 4'd0;
      if (col == 2'd3) begin
         case (row)
            2'd0: begin k.cls = OPER;  k.value = {1'b0, OP_ADD}; end
            2'd1: begin k.cls = OPER;  k.value = {1'b0, OP_SUB}; end
            2'd2: begin k.cls = OPER;  k.value = {1'b0, OP_MUL}; end
            default: begin k.cls = EQUAL; k.value = 4'd0; end
         endcase
      end else if (row == 2'd3) begin
         case (col)
            2'd0: begin k.cls = OPER;  k.value = {1'b0, OP_ADD}; end
            2'd1: begin k.cls = DIGIT; k.value = 4'd0; end
            default: begin k.cls = NONE; k.value = 4'd0; end
         endcase
      end else begin
         k.cls   = DIGIT;
         k.value = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end
      return k;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterized-width two-flop synchronizer; resets to all-ones (idle for active-low lines).
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces press/release and emits one gencon transaction per press.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic [3:0] col_n,
   input  logic       complete,
   output logic [3:0] row_n,
   output logic [3:0] keypad_input,
   output logic       read_input,
   output logic [2:0] operator_input,
   output logic       equal_input
);

   localparam int unsigned SW = $clog2(SCAN_DIV + 1);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    col_s;
   kp_state_t     state;
   logic [1:0]    row;
   logic [SW-1:0] scan_cnt;
   logic [DW-1:0] deb_cnt;
   logic [3:0]    latched;
   key_t          key_q;

   logic [3:0]    col_low;
   logic          one_low;
   logic [1:0]    col_idx;
   key_t          key_dec;

   sync2 #(.WIDTH(4)) u_col_sync (
      .clk  (clk),
      .nRST (nRST),
      .d    (col_n),
      .q    (col_s)
   );

   function automatic logic [3:0] drive(input logic [1:0] r);
      return ~(4'b0001 << r);
   endfunction

   always_comb begin
      col_low = ~col_s;
      one_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
      col_idx = 2'd0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (col_low[i]) col_idx = 2'(i);
      end
      key_dec = decode_key(row, col_idx);
   end

   // The debounce counter exits one short of its terminal value, so it never wraps.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state          <= SCAN;
         row            <= 2'd0;
         row_n          <= 4'b1110;
         scan_cnt       <= '0;
         deb_cnt        <= '0;
         latched        <= '1;
         key_q          <= '{cls: NONE, value: 4'd0};
         keypad_input   <= '0;
         read_input     <= 1'b0;
         operator_input <= '0;
         equal_input    <= 1'b0;
      end else begin
         read_input     <= 1'b0;
         operator_input <= '0;
         case (state)
            SCAN: begin
               if (scan_cnt == SCAN_LAST) begin
                  scan_cnt <= '0;
                  if (one_low) begin
                     state   <= DEBOUNCE;
                     latched <= col_s;
                     key_q   <= key_dec;
                     deb_cnt <= '0;
                  end else begin
                     row   <= row + 2'd1;
                     row_n <= drive(row + 2'd1);
                  end
               end else begin
                  scan_cnt <= scan_cnt + SW'(1);
               end
            end
            DEBOUNCE: begin
               if (col_s != latched) begin
                  state   <= SCAN;
                  row     <= row + 2'd1;
                  row_n   <= drive(row + 2'd1);
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  deb_cnt <= '0;
                  case (key_q.cls)
                     DIGIT: begin
                        keypad_input <= key_q.value;
                        state        <= EMIT_SETUP;
                     end
                     OPER: begin
                        operator_input <= key_q.value[2:0];
                        state          <= EMIT_STROBE;
                     end
                     EQUAL: begin
                        equal_input <= 1'b1;
                        state       <= EQ_WAIT;
                     end
                     default: state <= WAIT_RELEASE;
                  endcase
               end else begin
                  deb_cnt <= deb_cnt + DW'(1);
               end
            end
            EMIT_SETUP: begin
               read_input <= 1'b1;
               state      <= EMIT_STROBE;
            end
            EMIT_STROBE: begin
               state   <= WAIT_RELEASE;
               deb_cnt <= '0;
            end
            EQ_WAIT: begin
               if (complete) begin
                  equal_input <= 1'b0;
                  state       <= WAIT_RELEASE;
                  deb_cnt     <= '0;
               end
            end
            WAIT_RELEASE: begin
               if (col_s != 4'b1111) begin
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  state        <= SCAN;
                  row          <= 2'd0;
                  row_n        <= 4'b1110;
                  scan_cnt     <= '0;
                  deb_cnt      <= '0;
                  keypad_input <= '0;
               end else begin
                  deb_cnt <= deb_cnt + DW'(1);
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a combinational matrix model drives col_n from the pressed-key set.
module tb_keypad_scanner;

   localparam int SD  = 4;
   localparam int DEB = 16;

   logic        clk = 1'b0;
   logic        nRST = 1'b0;
   logic [3:0]  col_n;
   logic        complete = 1'b0;
   logic [3:0]  row_n;
   logic [3:0]  keypad_input;
   logic        read_input;
   logic [2:0]  operator_input;
   logic        equal_input;
   logic [15:0] pressed = '0;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk            (clk),
      .nRST           (nRST),
      .col_n          (col_n),
      .complete       (complete),
      .row_n          (row_n),
      .keypad_input   (keypad_input),
      .read_input     (read_input),
      .operator_input (operator_input),
      .equal_input    (equal_input)
   );

   // Key at row r, column c is bit r*4+c of pressed.
   always_comb begin
      col_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
   end

   // Event log: 1d = digit d strobe, 2o = operator pulse o, 30 = equal rise.
   logic [7:0] log_q[$];
   int         cyc = 0, rd_cyc = 0, rd_wide = 0, op_wide = 0;
   logic [3:0] prev_key = '0, rd_prev_key = '0;
   logic       prev_rd = 1'b0, prev_eq = 1'b0;
   logic [2:0] prev_op = '0;

   always @(posedge clk) begin
      cyc++;
      if (read_input) begin
         if (prev_rd) rd_wide++;
         else begin
            log_q.push_back({4'h1, keypad_input});
            rd_cyc      = cyc;
            rd_prev_key = prev_key;
         end
      end
      if (operator_input != 3'b000) begin
         if (prev_op != 3'b000) op_wide++;
         else log_q.push_back({5'b00100, operator_input});
      end
      if (equal_input && !prev_eq) log_q.push_back(8'h30);
      prev_rd  = read_input;
      prev_op  = operator_input;
      prev_eq  = equal_input;
      prev_key = keypad_input;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_log(input int n, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (log_q.size() > n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_key_zero(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (keypad_input == 4'd0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [7:0] log_at(input int i);
      if (i < log_q.size()) return log_q[i];
      return 8'hFF;
   endfunction

   task automatic press_key(input int idx, input string tag);
      int  b;
      bit  ok;
      b = log_q.size();
      pressed[idx] = 1'b1;
      wait_log(b, 400, ok);
      chk(tag, 32'(ok), 32'd1);
      step(8);
      pressed[idx] = 1'b0;
      step(DEB + 12);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int t0;
      bit ok;

      // Reset and scan stepping
      step(3);
      chk("rst_row_n", 32'(row_n), 32'hE);
      chk("rst_key", 32'(keypad_input), 32'd0);
      chk("rst_read", 32'(read_input), 32'd0);
      chk("rst_op", 32'(operator_input), 32'd0);
      chk("rst_eq", 32'(equal_input), 32'd0);
      nRST = 1'b1;
      step(SD - 1);
      chk("scan_row0_hold", 32'(row_n), 32'hE);
      step(1);
      chk("scan_row1", 32'(row_n), 32'hD);
      step(SD);
      chk("scan_row2", 32'(row_n), 32'hB);
      step(SD);
      chk("scan_row3", 32'(row_n), 32'h7);
      step(SD);
      chk("scan_wrap", 32'(row_n), 32'hE);

      // Digit 7 held well past debounce
      base = log_q.size();
      t0 = cyc;
      pressed[8] = 1'b1;
      wait_log(base, 300, ok);
      chk("dig_event", 32'(ok), 32'd1);
      chk("dig_value", 32'(log_at(base)), 32'h17);
      chk("dig_key_before", 32'(rd_prev_key), 32'd7);
      chk("dig_lat_min", 32'((rd_cyc - t0) >= DEB + 4), 32'd1);
      chk("dig_lat_max", 32'((rd_cyc - t0) <= DEB + 4 + 4 * SD), 32'd1);
      step(1);
      chk("dig_key_after", 32'(keypad_input), 32'd7);
      step(2 * DEB);
      chk("dig_no_repeat", 32'(log_q.size() - base), 32'd1);
      chk("dig_width", 32'(rd_wide), 32'd0);
      pressed[8] = 1'b0;
      step(2);
      chk("dig_key_in_release", 32'(keypad_input), 32'd7);
      wait_key_zero(ok);
      chk("dig_key_cleared", 32'(ok), 32'd1);
      chk("dig_rescan_row0", 32'(row_n), 32'hE);

      // Bouncing key 2, then a clean hold
      base = log_q.size();
      for (int i = 0; i < 20; i++) begin
         pressed[1] = ~pressed[1];
         step(3);
      end
      chk("bounce_quiet", 32'(log_q.size() - base), 32'd0);
      pressed[1] = 1'b1;
      wait_log(base, 300, ok);
      chk("bounce_event", 32'(ok), 32'd1);
      chk("bounce_value", 32'(log_at(base)), 32'h12);
      step(DEB);
      chk("bounce_single", 32'(log_q.size() - base), 32'd1);
      pressed[1] = 1'b0;
      wait_key_zero(ok);
      chk("bounce_key_cleared", 32'(ok), 32'd1);

      // Operator C
      base = log_q.size();
      pressed[11] = 1'b1;
      wait_log(base, 300, ok);
      chk("op_event", 32'(ok), 32'd1);
      chk("op_value", 32'(log_at(base)), 32'h24);
      chk("op_width", 32'(op_wide), 32'd0);
      chk("op_key_zero", 32'(keypad_input), 32'd0);
      step(2 * DEB);
      chk("op_single", 32'(log_q.size() - base), 32'd1);
      pressed[11] = 1'b0;
      step(DEB + 12);

      // Ghosting: 4 and 5 together on one row
      base = log_q.size();
      pressed[4] = 1'b1;
      pressed[5] = 1'b1;
      step(4 * DEB);
      chk("ghost_none", 32'(log_q.size() - base), 32'd0);
      pressed[4] = 1'b0;
      pressed[5] = 1'b0;
      step(10);

      // '#' is swallowed
      base = log_q.size();
      pressed[14] = 1'b1;
      step(3 * DEB + 4 * SD);
      chk("hash_none", 32'(log_q.size() - base), 32'd0);
      chk("hash_key_zero", 32'(keypad_input), 32'd0);
      pressed[14] = 1'b0;
      step(DEB + 12);

      // Equal handshake; D released while waiting
      base = log_q.size();
      pressed[15] = 1'b1;
      wait_log(base, 300, ok);
      chk("eq_event", 32'(ok), 32'd1);
      chk("eq_value", 32'(log_at(base)), 32'h30);
      step(10);
      pressed[15] = 1'b0;
      step(10);
      chk("eq_hold_after_release", 32'(equal_input), 32'd1);
      complete = 1'b1;
      #1;
      chk("eq_before_sample", 32'(equal_input), 32'd1);
      step(1);
      chk("eq_drop", 32'(equal_input), 32'd0);
      complete = 1'b0;
      step(DEB + 12);

      // Reset while in EQ_WAIT
      base = log_q.size();
      pressed[15] = 1'b1;
      wait_log(base, 300, ok);
      chk("eqrst_event", 32'(ok), 32'd1);
      step(3);
      #2;
      nRST = 1'b0;
      #1;
      chk("eqrst_eq_low", 32'(equal_input), 32'd0);
      chk("eqrst_row_n", 32'(row_n), 32'hE);
      pressed[15] = 1'b0;
      step(3);
      nRST = 1'b1;
      step(3 * DEB);
      chk("eqrst_stays_low", 32'(equal_input), 32'd0);
      chk("eqrst_no_event", 32'(log_q.size() - base), 32'd1);

      // Key sequence * 1 C * 1 D
      base = log_q.size();
      press_key(12, "seq_star0");
      press_key(0, "seq_one0");
      press_key(11, "seq_c");
      press_key(12, "seq_star1");
      press_key(0, "seq_one1");
      pressed[15] = 1'b1;
      wait_log(log_q.size(), 300, ok);
      chk("seq_d", 32'(ok), 32'd1);
      step(5);
      complete = 1'b1;
      step(1);
      complete = 1'b0;
      pressed[15] = 1'b0;
      step(DEB + 12);
      chk("seq_e0", 32'(log_at(base)), 32'h21);
      chk("seq_e1", 32'(log_at(base + 1)), 32'h11);
      chk("seq_e2", 32'(log_at(base + 2)), 32'h24);
      chk("seq_e3", 32'(log_at(base + 3)), 32'h21);
      chk("seq_e4", 32'(log_at(base + 4)), 32'h11);
      chk("seq_e5", 32'(log_at(base + 5)), 32'h30);
      chk("seq_count", 32'(log_q.size() - base), 32'd6);
      chk("seq_eq_low", 32'(equal_input), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
